// File: rtl/trsq8_pkg.sv
// Shared TRSQ8 definitions: instruction constants, skip-select codes and the
// fetch-stage run/halt state encoding.
package trsq8_pkg;

  localparam int          INSTR_W   = 15;
  localparam logic [14:0] NOP_INSTR = 15'h0000;

  typedef enum logic [1:0] {
    SK_NONE = 2'b00,
    SK_Z    = 2'b01,
    SK_C    = 2'b10
  } sk_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

  function automatic logic skip_taken(input logic [1:0] sel, input logic z, input logic c);
    return ((sel == SK_Z) && z) || ((sel == SK_C) && c);
  endfunction

endpackage

// File: rtl/sequencer_if.sv
// Return-stack port bundle between the sequencer (master) and return_stack (slave).
// push/pop are single-cycle strobes acted on at the next rising edge, never both high;
// top/full/empty always reflect the current registered stack contents.
interface sequencer_if #(
  parameter int PC_WIDTH = 10
);
  import trsq8_pkg::*;

  logic                push;
  logic                pop;
  logic [PC_WIDTH-1:0] push_addr;
  logic [PC_WIDTH-1:0] top;
  logic                full;
  logic                empty;

  modport master (output push, output pop, output push_addr,
                  input  top,  input  full, input  empty);
  modport slave  (input  push, input  pop, input  push_addr,
                  output top,  output full, output empty);

endinterface

// File: rtl/sequencer_return_stack.sv
// Circular hardware return stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched (the caller flags the underflow).
module return_stack #(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  sequencer_if.slave stk
);

  localparam int                PTR_W    = $clog2(STACK_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = 1;
  localparam logic [PTR_W:0]    CNT_ONE  = 1;
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(STACK_DEPTH);

  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]    sp_q, sp_d;
  logic [PTR_W:0]      cnt_q, cnt_d;

  // sp_q is the next free slot; once full it also points at the oldest entry.
  assign stk.full  = (cnt_q == CNT_FULL);
  assign stk.empty = (cnt_q == '0);
  assign stk.top   = mem_q[sp_q - PTR_ONE];

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (stk.push) begin
      sp_d = sp_q + PTR_ONE;
      if (!stk.full) cnt_d = cnt_q + CNT_ONE;
    end else if (stk.pop && !stk.empty) begin
      sp_d  = sp_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (stk.push) mem_q[sp_q] <= stk.push_addr;
  end

endmodule

// File: rtl/sequencer.sv
// TRSQ8 fetch/program-flow stage: PC, ROM addressing, instruction register,
// jump/call/return/skip/halt handling and the RUN/HALT state machine.
module sequencer
  import trsq8_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk_ip,
  input  logic                rst_ip,
  input  logic                run_ip,
  output logic [PC_WIDTH-1:0] rom_addr_op,
  input  logic [14:0]         rom_data_ip,
  output logic [14:0]         instr_op,
  input  logic                jump_op,
  input  logic                return_op,
  input  logic                halt_op,
  input  logic [1:0]          sk_sel_op,
  input  logic                zero_ip,
  input  logic                carry_ip,
  output logic [PC_WIDTH-1:0] pc_op,
  output logic                halted_op,
  output logic                stack_err_op
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [14:0]         instr_q, instr_d;
  logic                err_q, err_d;

  sequencer_if #(.PC_WIDTH(PC_WIDTH)) stk ();

  return_stack #(
    .PC_WIDTH   (PC_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_return_stack (
    .clk_i(clk_ip),
    .rst_i(rst_ip),
    .stk  (stk)
  );

  assign pc_inc        = pc_q + PC_ONE;
  assign stk.push_addr = pc_q;

  // pc_q always addresses the word now on rom_data_ip, so it is the return address.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_inc;
    instr_d  = rom_data_ip;
    err_d    = err_q;
    stk.push = 1'b0;
    stk.pop  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_op) begin
          state_d = HALT;
          instr_d = NOP_INSTR;
          pc_d    = pc_q;
        end else if (return_op) begin
          stk.pop = 1'b1;
          instr_d = NOP_INSTR;
          if (stk.empty) begin
            pc_d  = '0;
            err_d = 1'b1;
          end else begin
            pc_d = stk.top;
          end
        end else if (jump_op) begin
          pc_d    = instr_q[PC_WIDTH-1:0];
          instr_d = NOP_INSTR;
          if (instr_q[12]) begin
            stk.push = 1'b1;
            if (stk.full) err_d = 1'b1;
          end
        end else if (skip_taken(sk_sel_op, zero_ip, carry_ip)) begin
          instr_d = NOP_INSTR;
        end
      end
      HALT: begin
        instr_d = NOP_INSTR;
        pc_d    = pc_q;
        if (run_ip) begin
          state_d = RUN;
          instr_d = rom_data_ip;
          pc_d    = pc_inc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_ip) begin
    if (rst_ip) begin
      state_q <= RUN;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign rom_addr_op  = rst_ip ? '0 : pc_d;
  assign instr_op     = instr_q;
  assign pc_op        = pc_q;
  assign halted_op    = (state_q == HALT);
  assign stack_err_op = err_q;

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: synchronous ROM and a tiny decoder model around the DUT.
module tb_sequencer;

  localparam int PW = 10;
  localparam logic [14:0] I_HALT = 15'h2000;
  localparam logic [14:0] I_RET  = 15'h2001;
  localparam logic [14:0] I_SKZ  = 15'h2002;
  localparam logic [14:0] I_SKC  = 15'h2003;
  localparam int TGT [10] = '{'h100, 'h200, 'h300, 'h080, 'h180,
                              'h081, 'h301, 'h201, 'h101, 'h000};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          zero = 1'b0;
  logic          carry = 1'b0;
  logic [PW-1:0] rom_addr, pc;
  logic [14:0]   rom_data = 15'h0000;
  logic [14:0]   instr;
  logic          jump, ret, halt, halted, err;
  logic [1:0]    sk_sel;
  logic [14:0]   mem [1024];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  assign jump   = (instr[14:13] == 2'b11);
  assign ret    = (instr == I_RET);
  assign halt   = (instr == I_HALT);
  assign sk_sel = (instr == I_SKZ) ? 2'b01 : (instr == I_SKC) ? 2'b10 : 2'b00;

  sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(4)) dut (
    .clk_ip      (clk),
    .rst_ip      (rst),
    .run_ip      (run),
    .rom_addr_op (rom_addr),
    .rom_data_ip (rom_data),
    .instr_op    (instr),
    .jump_op     (jump),
    .return_op   (ret),
    .halt_op     (halt),
    .sk_sel_op   (sk_sel),
    .zero_ip     (zero),
    .carry_ip    (carry),
    .pc_op       (pc),
    .halted_op   (halted),
    .stack_err_op(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 1024; i++) mem[i] = 15'h0800 | 15'(i);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; zero = 1'b0; carry = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_default();
    rst = 1'b1;
    step();
    step();
    checks++; if (rom_addr !== 10'h000) begin errors++; $display("FAIL reset_rom_addr: got %h expected 000", rom_addr); end
    checks++; if (instr !== 15'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (instr !== (15'h0800 + 15'(k))) begin errors++; $display("FAIL straight_instr[%0d]: got %h expected %h", k, instr, 15'h0800 + 15'(k)); end
      checks++; if (pc !== PW'(k + 1)) begin errors++; $display("FAIL straight_pc[%0d]: got %h expected %h", k, pc, PW'(k + 1)); end
    end
  endtask

  task automatic test_jump();
    load_default();
    mem[5] = 15'h6100;
    do_reset();
    repeat (6) step();
    checks++; if (instr !== 15'h6100) begin errors++; $display("FAIL jump_instr: got %h expected 6100", instr); end
    checks++; if (rom_addr !== 10'h100) begin errors++; $display("FAIL jump_rom_addr: got %h expected 100", rom_addr); end
    step();
    checks++; if (instr !== 15'h0000) begin errors++; $display("FAIL jump_bubble: got %h expected 0000", instr); end
    checks++; if (pc !== 10'h100) begin errors++; $display("FAIL jump_pc: got %h expected 100", pc); end
    step();
    checks++; if (instr !== 15'h0900) begin errors++; $display("FAIL jump_target: got %h expected 0900", instr); end
    checks++; if (pc !== 10'h101) begin errors++; $display("FAIL jump_pc2: got %h expected 101", pc); end
  endtask

  task automatic test_call_return();
    load_default();
    mem['h010] = 15'h7040;
    mem['h040] = I_RET;
    do_reset();
    repeat (17) step();
    checks++; if (instr !== 15'h7040) begin errors++; $display("FAIL call_instr: got %h expected 7040", instr); end
    step();
    checks++; if (instr !== 15'h0000 || pc !== 10'h040) begin errors++; $display("FAIL call_bubble: got %h/%h expected 0000/040", instr, pc); end
    step();
    checks++; if (instr !== I_RET) begin errors++; $display("FAIL ret_instr: got %h expected %h", instr, I_RET); end
    checks++; if (rom_addr !== 10'h011) begin errors++; $display("FAIL ret_rom_addr: got %h expected 011", rom_addr); end
    step();
    checks++; if (instr !== 15'h0000 || pc !== 10'h011) begin errors++; $display("FAIL ret_bubble: got %h/%h expected 0000/011", instr, pc); end
    step();
    checks++; if (instr !== 15'h0811) begin errors++; $display("FAIL ret_resume: got %h expected 0811", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL call_err: got %b expected 0", err); end
  endtask

  task automatic test_skip();
    load_default();
    mem[0] = I_SKZ; mem[2] = I_SKZ; mem[4] = I_SKC; mem[6] = I_SKC;
    do_reset();
    step();
    zero = 1'b1;
    step();
    checks++; if (instr !== 15'h0000 || pc !== 10'h002) begin errors++; $display("FAIL skz_taken: got %h/%h expected 0000/002", instr, pc); end
    zero = 1'b0;
    step();
    step();
    checks++; if (instr !== 15'h0803) begin errors++; $display("FAIL skz_not_taken: got %h expected 0803", instr); end
    step();
    carry = 1'b1;
    step();
    checks++; if (instr !== 15'h0000) begin errors++; $display("FAIL skc_taken: got %h expected 0000", instr); end
    carry = 1'b0;
    step();
    zero = 1'b1;
    step();
    checks++; if (instr !== 15'h0807) begin errors++; $display("FAIL skc_not_taken: got %h expected 0807", instr); end
    zero = 1'b0;
  endtask

  task automatic test_halt();
    load_default();
    mem['h020] = I_HALT;
    mem['h022] = I_HALT;
    do_reset();
    repeat (33) step();
    checks++; if (instr !== I_HALT || halted !== 1'b0) begin errors++; $display("FAIL halt_decode: got %h/%b expected %h/0", instr, halted, I_HALT); end
    checks++; if (rom_addr !== 10'h021) begin errors++; $display("FAIL halt_rom_addr: got %h expected 021", rom_addr); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (halted !== 1'b1 || instr !== 15'h0000 || pc !== 10'h021) begin errors++; $display("FAIL halt_hold[%0d]: got %b/%h/%h expected 1/0000/021", i, halted, instr, pc); end
    end
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if (halted !== 1'b0 || instr !== 15'h0821 || pc !== 10'h022) begin errors++; $display("FAIL halt_resume: got %b/%h/%h expected 0/0821/022", halted, instr, pc); end
    run = 1'b1;
    step();
    checks++; if (instr !== I_HALT || halted !== 1'b0) begin errors++; $display("FAIL halt2_decode: got %h/%b expected %h/0", instr, halted, I_HALT); end
    step();
    checks++; if (halted !== 1'b1 || instr !== 15'h0000) begin errors++; $display("FAIL halt2_min: got %b/%h expected 1/0000", halted, instr); end
    step();
    checks++; if (halted !== 1'b0 || instr !== 15'h0823) begin errors++; $display("FAIL halt2_resume: got %b/%h expected 0/0823", halted, instr); end
    run = 1'b0;
  endtask

  task automatic test_stack_err();
    load_default();
    mem['h000] = 15'h7100; mem['h100] = 15'h7200; mem['h200] = 15'h7300;
    mem['h300] = 15'h7080; mem['h080] = 15'h7180;
    mem['h180] = I_RET; mem['h081] = I_RET; mem['h301] = I_RET;
    mem['h201] = I_RET; mem['h101] = I_RET;
    do_reset();
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      checks++; if (pc !== PW'(TGT[k]) || instr !== 15'h0000) begin errors++; $display("FAIL flow_target[%0d]: got %h/%h expected %h/0000", k, pc, instr, PW'(TGT[k])); end
      checks++; if (err !== (k >= 4)) begin errors++; $display("FAIL stack_err[%0d]: got %b expected %b", k, err, k >= 4); end
      step();
      checks++; if (instr !== mem[TGT[k]]) begin errors++; $display("FAIL flow_instr[%0d]: got %h expected %h", k, instr, mem[TGT[k]]); end
    end
    rst = 1'b1;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", err); end
    rst = 1'b0;
    step();
    checks++; if (err !== 1'b0 || instr !== 15'h7100) begin errors++; $display("FAIL err_after_reset: got %b/%h expected 0/7100", err, instr); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_call_return();
    test_skip();
    test_halt();
    test_stack_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
